// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: control/status bundle between the multicycle controller and its datapath
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;
  logic [3:0] state;
  modport master (
    input  op, funct, zero,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, pcen, alucontrol, state
  );
  modport slave (
    output op, funct, zero,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, pcen, alucontrol, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore FSM sequencing a multicycle MIPS datapath with shared memory
module mips_multicycle_ctrl #(
  parameter bit SUPPORT_ADDI = 1'b1,
  parameter bit SUPPORT_J    = 1'b1
) (
  input logic                        clk,
  input logic                        reset,
  mips_multicycle_ctrl_if.master     bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
    MEMWRITE = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9,
    ADDIWB = 4'd10, JUMP = 4'd11
  } state_t;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  state_t     state_q, state_d;
  logic       pcwrite, branch;
  logic [1:0] aluop;
  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= FETCH;
    else state_q <= state_d;
  // Next state and Moore decode; unused codes fall back to FETCH with everything off
  always_comb begin
    state_d      = FETCH;
    bus.iord     = 1'b0;
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regwrite = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    aluop        = 2'b00;
    case (state_q)
      FETCH: begin
        bus.alusrcb = 2'b01;
        bus.irwrite = 1'b1;
        pcwrite     = 1'b1;
        state_d     = DECODE;
      end
      DECODE: begin
        bus.alusrcb = 2'b11;
        state_d = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                  (bus.op == OP_R)                     ? EXECUTE :
                  (bus.op == OP_BEQ)                   ? BRANCH :
                  (SUPPORT_ADDI && bus.op == OP_ADDI)  ? ADDIEX :
                  (SUPPORT_J && bus.op == OP_J)        ? JUMP : FETCH;
      end
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        bus.iord = 1'b1;
        state_d  = MEMWB;
      end
      MEMWB: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
      end
      MEMWRITE: begin
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
      end
      EXECUTE: begin
        bus.alusrca = 1'b1;
        aluop       = 2'b10;
        state_d     = ALUWB;
      end
      ALUWB: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
      end
      BRANCH: begin
        bus.alusrca = 1'b1;
        aluop       = 2'b01;
        bus.pcsrc   = 2'b01;
        branch      = 1'b1;
      end
      ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = ADDIWB;
      end
      ADDIWB: bus.regwrite = 1'b1;
      JUMP: begin
        bus.pcsrc = 2'b10;
        pcwrite   = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end
  assign bus.pcen       = pcwrite | (branch & bus.zero);
  assign bus.state      = state_q;
  assign bus.alucontrol = aluop == 2'b00        ? 3'b010 :
                          aluop == 2'b01        ? 3'b110 :
                          bus.funct == 6'b100010 ? 3'b110 :
                          bus.funct == 6'b100100 ? 3'b000 :
                          bus.funct == 6'b100101 ? 3'b001 :
                          bus.funct == 6'b101010 ? 3'b111 : 3'b010;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed and randomized instruction sequences against a path/table reference model
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   path[$];
  mips_multicycle_ctrl_if bus();
  mips_multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc} per step of an instruction
  function automatic logic [10:0] ctl_of(input int s);
    case (s)
      0:  return 11'b0010000_01_00;
      1:  return 11'b0000000_11_00;
      2:  return 11'b0000001_10_00;
      3:  return 11'b1000000_00_00;
      4:  return 11'b0000110_00_00;
      5:  return 11'b1100000_00_00;
      6:  return 11'b0000001_00_00;
      7:  return 11'b0001010_00_00;
      8:  return 11'b0000001_00_01;
      9:  return 11'b0000001_10_00;
      10: return 11'b0000010_00_00;
      11: return 11'b0000000_00_10;
      default: return 11'b0;
    endcase
  endfunction
  function automatic logic [2:0] alu_of(input int s, input logic [5:0] f);
    if (s == 8) return 3'b110;
    if (s != 6) return 3'b010;
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction
  task automatic check_step(input int s);
    check("state", 32'(bus.state), 32'(s));
    check("ctl", 32'({bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
                      bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc}), 32'(ctl_of(s)));
    check("pcen", 32'(bus.pcen), 32'(s == 0 || s == 11 || (s == 8 && bus.zero)));
    check("alucontrol", 32'(bus.alucontrol), 32'(alu_of(s, bus.funct)));
  endtask
  // Expected state walk for one instruction, built from the opcode alone
  task automatic build_path(input logic [5:0] op);
    path.delete();
    path.push_back(0);
    path.push_back(1);
    case (op)
      6'b100011: begin path.push_back(2); path.push_back(3); path.push_back(4); end
      6'b101011: begin path.push_back(2); path.push_back(5); end
      6'b000000: begin path.push_back(6); path.push_back(7); end
      6'b000100: path.push_back(8);
      6'b001000: begin path.push_back(9); path.push_back(10); end
      6'b000010: path.push_back(11);
      default: ;
    endcase
  endtask
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input int zf);
    build_path(op);
    bus.op    = op;
    bus.funct = f;
    foreach (path[i]) begin
      bus.zero = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
      #1;
      check_step(path[i]);
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    logic [5:0] ops [7];
    logic [5:0] fns [5];
    logic [5:0] op, fn;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    reset     = 1'b1;
    bus.op    = 6'b0;
    bus.funct = 6'b0;
    bus.zero  = 1'b0;
    #12;
    check_step(0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    run_instr(6'b100011, 6'b000000, -1);
    run_instr(6'b101011, 6'b000000, -1);
    run_instr(6'b000000, 6'b100010, -1);
    run_instr(6'b000000, 6'b101010, -1);
    run_instr(6'b000000, 6'b100101, -1);
    run_instr(6'b000000, 6'b100100, -1);
    run_instr(6'b000000, 6'b111111, -1);
    run_instr(6'b000100, 6'b000000, 1);
    run_instr(6'b000100, 6'b000000, 0);
    run_instr(6'b001000, 6'b000000, -1);
    run_instr(6'b000010, 6'b000000, -1);
    run_instr(6'b111111, 6'b000000, -1);
    bus.op    = 6'b000000;
    bus.funct = 6'b100000;
    #1;
    check_step(0);
    @(posedge clk);
    #1;
    check_step(1);
    @(posedge clk);
    #1;
    check_step(6);
    #1;
    reset = 1'b1;
    #1;
    check_step(0);
    @(posedge clk);
    #1;
    check_step(0);
    #2;
    reset = 1'b0;
    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      fn = ($urandom_range(0, 5) == 5) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr(op, fn, -1);
    end
    #1;
    check_step(0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
